// File: rtl/galois_mult_arbiter.sv
// ---------------------------------------------------------------------------
// galois_mult_arbiter
//   Round-robin front end that shares one external GF(p) multiplier among
//   N_REQ requesters. One operation is in flight at a time:
//     IDLE  -> grant one requester, latch its operands, hold multiplier reset
//     START -> one-cycle mult_en pulse
//     WAIT  -> wait for sticky mult_done, bounded by TIMEOUT cycles
//     RESP  -> present result until resp_ready
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   req_valid/req_ready per-requester request / one-hot acceptance strobe
//   req_a, req_b        packed operands, requester i at [i*N_BITS +: N_BITS]
//   resp_*              result channel (valid/ready, owner id, data, timeout)
//   mult_*              shared multiplier control, operands and result
// ---------------------------------------------------------------------------
module galois_mult_arbiter #(
  parameter int N_BITS  = 254,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*N_BITS-1:0]    req_a,
  input  logic [N_REQ*N_BITS-1:0]    req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(N_REQ)-1:0]   resp_id,
  output logic [N_BITS-1:0]          resp_data,
  output logic                       resp_err,
  output logic                       mult_rst,
  output logic                       mult_en,
  output logic [N_BITS-1:0]          mult_num1,
  output logic [N_BITS-1:0]          mult_num2,
  input  logic [N_BITS-1:0]          mult_product,
  input  logic                       mult_done
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_found;
  logic [N_BITS-1:0]  op_a, op_b;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timeout_hit;

  // Operands only change on a grant, so they are stable through START/WAIT.
  assign mult_num1 = op_a;
  assign mult_num2 = op_b;

  // Last WAIT cycle allowed; mult_done in the same cycle still wins.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Round-robin search starting one past the previous winner.
  always_comb begin
    logic [ID_W-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + 1 + k) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    mult_rst   = 1'b0;
    mult_en    = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        mult_rst = 1'b1;
        if (gnt_found) begin
          // Strobe is combinational; gate it so nothing is acknowledged while
          // the block is held in reset.
          req_ready[gnt_idx] = rst_n;
          state_nxt          = START;
        end
      end
      START: begin
        mult_en   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mult_done || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(N_REQ - 1);
      resp_id    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            last_grant <= gnt_idx;
            resp_id    <= gnt_idx;
            op_a       <= req_a[gnt_idx*N_BITS +: N_BITS];
            op_b       <= req_b[gnt_idx*N_BITS +: N_BITS];
          end
        end
        START: wait_cnt <= '0;
        WAIT: begin
          if (mult_done) begin
            resp_data <= mult_product;
            resp_err  <= 1'b0;
          end else if (timeout_hit) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_galois_mult_arbiter.sv
module tb_galois_mult_arbiter;
  localparam int NB = 254;
  localparam int NR = 4;
  localparam int TO = 16;
  localparam logic [NB-1:0] P =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NR-1:0]       req_valid = '0;
  logic [NR-1:0][NB-1:0] a_op = '0;
  logic [NR-1:0][NB-1:0] b_op = '0;
  logic [NR-1:0]       req_ready;
  logic                resp_valid;
  logic                resp_ready = 1'b1;
  logic [1:0]          resp_id;
  logic [NB-1:0]       resp_data;
  logic                resp_err;
  logic                mult_rst, mult_en;
  logic [NB-1:0]       mult_num1, mult_num2;
  logic [NB-1:0]       mult_product = '0;
  logic                mult_done = 1'b0;
  logic                done_kill = 1'b0;
  logic [2:0]          busy = '0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]    id;
    logic [NB-1:0] data;
    logic          err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  galois_mult_arbiter #(.N_BITS(NB), .N_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(a_op), .req_b(b_op), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err),
    .mult_rst(mult_rst), .mult_en(mult_en),
    .mult_num1(mult_num1), .mult_num2(mult_num2),
    .mult_product(mult_product), .mult_done(mult_done)
  );

  function automatic logic [NB-1:0] mulmod(input logic [NB-1:0] x, input logic [NB-1:0] y);
    logic [2*NB-1:0] t;
    t = {{NB{1'b0}}, x} * {{NB{1'b0}}, y};
    t = t % {{NB{1'b0}}, P};
    return t[NB-1:0];
  endfunction

  // Stand-in multiplier: result 4 edges after the mult_en edge, sticky done,
  // synchronous clear by mult_rst.
  always @(posedge clk) begin
    if (mult_rst) begin
      mult_done <= 1'b0;
      busy      <= '0;
    end else if (mult_en) begin
      mult_product <= mulmod(mult_num1, mult_num2);
      busy         <= 3'd4;
      mult_done    <= 1'b0;
    end else if (busy != 0) begin
      busy <= busy - 3'd1;
      if (busy == 3'd1 && !done_kill) mult_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction: grant check, push expectation, latency check, pop/compare,
  // optional backpressure hold, handshake.
  task automatic do_txn(input int exp_id, input logic exp_err, input int exp_lat,
                        input int bp, input logic drop, output logic [NB-1:0] obs_data);
    int n;
    logic [NR-1:0] oh;
    logic [NB-1:0] hold_d;
    logic [1:0]    hold_id;
    exp_t e, got;
    #1;
    n = 0;
    while (req_ready == '0 && n < 40) begin @(negedge clk); n++; end
    oh = '0;
    oh[exp_id] = 1'b1;
    chk("grant", NB'(req_ready), NB'(oh));
    e.id   = exp_id[1:0];
    e.err  = exp_err;
    e.data = exp_err ? '0 : mulmod(a_op[exp_id], b_op[exp_id]);
    sb.push_back(e);
    @(negedge clk);
    chk("start_en", NB'(mult_en), NB'(1'b1));
    chk("start_rst", NB'(mult_rst), NB'(1'b0));
    chk("start_ready", NB'(req_ready), NB'(0));
    chk("start_num1", mult_num1, a_op[exp_id]);
    chk("start_num2", mult_num2, b_op[exp_id]);
    if (drop) req_valid = '0;
    // Operands must have been captured on the grant only.
    a_op[exp_id] = ~a_op[exp_id];
    n = 1;
    while (!resp_valid && n < 60) begin @(negedge clk); n++; end
    chk("latency", NB'(n), NB'(exp_lat));
    if (sb.size() == 0) begin
      chk("sb_nonempty", NB'(0), NB'(1));
      got = e;
    end else begin
      got = sb.pop_front();
    end
    chk("resp_id", NB'(resp_id), NB'(got.id));
    chk("resp_data", resp_data, got.data);
    chk("resp_err", NB'(resp_err), NB'(got.err));
    obs_data = resp_data;
    hold_d   = resp_data;
    hold_id  = resp_id;
    if (bp > 0) req_valid = '1;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk("bp_valid", NB'(resp_valid), NB'(1'b1));
      chk("bp_data", resp_data, hold_d);
      chk("bp_id", NB'(resp_id), NB'(hold_id));
      chk("bp_ready", NB'(req_ready), NB'(0));
    end
    if (bp > 0) req_valid = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("resp_done", NB'(resp_valid), NB'(1'b0));
  endtask

  initial begin
    logic [NB-1:0] d;
    int n;
    bit stale;
    // Reset values, with requests pending to exercise the strobe gating.
    req_valid = '1;
    @(negedge clk);
    #1;
    chk("rst_ready", NB'(req_ready), NB'(0));
    chk("rst_valid", NB'(resp_valid), NB'(1'b0));
    chk("rst_err", NB'(resp_err), NB'(1'b0));
    chk("rst_id", NB'(resp_id), NB'(0));
    chk("rst_data", resp_data, NB'(0));
    chk("rst_en", NB'(mult_en), NB'(1'b0));
    chk("rst_mrst", NB'(mult_rst), NB'(1'b1));
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request 3*5.
    a_op[0] = NB'(3); b_op[0] = NB'(5); req_valid = 4'b0001;
    do_txn(0, 1'b0, 7, 0, 1'b1, d);
    chk("single_15", d, NB'(15));

    // Boundary operands.
    a_op[2] = P - NB'(1); b_op[2] = P - NB'(1); req_valid = 4'b0100;
    do_txn(2, 1'b0, 7, 0, 1'b1, d);
    chk("pm1_sq", d, NB'(1));
    a_op[3] = '0; b_op[3] = P - NB'(1); req_valid = 4'b1000;
    do_txn(3, 1'b0, 7, 0, 1'b1, d);
    chk("zero_op", d, NB'(0));

    // All requesters held valid: 0,1,2,3,0.
    for (int i = 0; i < NR; i++) begin
      a_op[i] = NB'({$urandom, $urandom, $urandom, $urandom});
      b_op[i] = NB'({$urandom, $urandom, $urandom, $urandom});
    end
    req_valid = '1;
    do_txn(0, 1'b0, 7, 0, 1'b0, d);
    do_txn(1, 1'b0, 7, 0, 1'b0, d);
    do_txn(2, 1'b0, 7, 0, 1'b0, d);
    do_txn(3, 1'b0, 7, 0, 1'b0, d);
    do_txn(0, 1'b0, 7, 0, 1'b1, d);

    // Backpressure for 10 cycles.
    req_valid = 4'b0010; resp_ready = 1'b0;
    do_txn(1, 1'b0, 7, 10, 1'b1, d);

    // Timeout, then recovery.
    done_kill = 1'b1; req_valid = 4'b0100;
    do_txn(2, 1'b1, TO + 2, 0, 1'b1, d);
    chk("to_data", d, NB'(0));
    done_kill = 1'b0; req_valid = 4'b1000;
    do_txn(3, 1'b0, 7, 0, 1'b1, d);

    // Reset during WAIT.
    req_valid = 4'b0010;
    #1;
    n = 0;
    while (req_ready == '0 && n < 40) begin @(negedge clk); n++; end
    chk("mid_grant", NB'(req_ready), NB'(4'b0010));
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("mid_ready", NB'(req_ready), NB'(0));
    chk("mid_valid", NB'(resp_valid), NB'(1'b0));
    chk("mid_err", NB'(resp_err), NB'(1'b0));
    chk("mid_id", NB'(resp_id), NB'(0));
    chk("mid_data", resp_data, NB'(0));
    chk("mid_en", NB'(mult_en), NB'(1'b0));
    chk("mid_mrst", NB'(mult_rst), NB'(1'b1));
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) stale = 1'b1;
    end
    chk("no_stale", NB'(stale), NB'(1'b0));
    req_valid = '1;
    do_txn(0, 1'b0, 7, 0, 1'b1, d);

    chk("sb_empty", NB'(sb.size()), NB'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
